// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron trainer: FSM state encoding,
// counter-width helpers and a saturating adder used for weight/bias updates.
package perceptron_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrainMac,
    StTrainUpd,
    StDone,
    StInferMac
  } state_e;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index addressing n entries (0..n-1), never below one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a + b clipped to the signed range of a width-bit word.
  function automatic int sat_add(int a, int b, int unsigned width);
    longint s;
    longint hi;
    longint lo;
    s  = longint'(a) + longint'(b);
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) return int'(hi);
    if (s < lo) return int'(lo);
    return int'(s);
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Sequential single-multiplier dot-product engine shared by training and inference.
// Step 0 seeds the accumulator with init; sum is the value the next edge will store.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int unsigned INP_DIM = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned W_W     = 8,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned IDX_W   = idx_w(INP_DIM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    step,
  input  logic signed [ACC_W-1:0] init,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [W_W-1:0]   b,
  output logic [IDX_W-1:0]        idx,
  output logic                    last,
  output logic signed [ACC_W-1:0] sum,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] prod;
  logic [IDX_W-1:0]        idx_q;

  assign last = (idx_q == IDX_W'(INP_DIM - 1));
  assign base = (idx_q == '0) ? init : acc_q;
  assign prod = ACC_W'(a) * ACC_W'(b);
  assign sum  = base + prod;
  assign acc  = acc_q;
  assign idx  = idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (step) begin
      acc_q <= sum;
      idx_q <= last ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer with a sample buffer, epoch loop and inference path.
// Define PERCEPTRON_BIAS_EN to add a trainable bias term.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int unsigned INP_DIM    = 2,
  parameter int unsigned N_SAMPLES  = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned W_W        = 8,
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned MAX_EPOCHS = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [INP_DIM*DATA_W-1:0]     load_x,
  input  logic                          load_y,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic [cnt_w(MAX_EPOCHS)-1:0]  epoch_cnt,
  output logic [INP_DIM*W_W-1:0]        w_out,
  input  logic                          infer_valid,
  output logic                          infer_ready,
  input  logic [INP_DIM*DATA_W-1:0]     infer_x,
  output logic                          pred_valid,
  output logic                          pred
);

  localparam int unsigned CntW  = cnt_w(N_SAMPLES);
  localparam int unsigned SIdxW = idx_w(N_SAMPLES);
  localparam int unsigned EIdxW = idx_w(INP_DIM);
  localparam int unsigned EpW   = cnt_w(MAX_EPOCHS);
  localparam logic [CntW-1:0]  NFull = CntW'(N_SAMPLES);
  localparam logic [SIdxW-1:0] SLast = SIdxW'(N_SAMPLES - 1);
  localparam logic [EpW-1:0]   EpMax = EpW'(MAX_EPOCHS);

  state_e                     state_q;
  logic [INP_DIM*DATA_W-1:0]  buf_x_q [N_SAMPLES];
  logic [N_SAMPLES-1:0]       buf_y_q;
  logic [INP_DIM*DATA_W-1:0]  infer_x_q;
  logic signed [W_W-1:0]      w_q   [INP_DIM];
  logic signed [W_W-1:0]      w_upd [INP_DIM];
  logic [CntW-1:0]            cnt_q;
  logic [CntW-1:0]            err_q;
  logic [CntW-1:0]            err_next;
  logic [SIdxW-1:0]           sidx_q;
  logic [EpW-1:0]             epoch_q;

  logic                       load_acc;
  logic [INP_DIM*DATA_W-1:0]  cur_x;
  logic [INP_DIM*DATA_W-1:0]  mac_x;
  logic                       cur_y;
  logic                       act;
  logic                       mis;
  logic signed [DATA_W-1:0]   xk;

  logic                       mac_clear;
  logic                       mac_step;
  logic signed [ACC_W-1:0]    mac_init;
  logic signed [DATA_W-1:0]   mac_a;
  logic signed [W_W-1:0]      mac_b;
  logic [EIdxW-1:0]           mac_idx;
  logic                       mac_last;
  logic signed [ACC_W-1:0]    mac_sum;
  logic signed [ACC_W-1:0]    mac_acc;

  assign load_acc  = load_valid && load_ready;
  assign cur_x     = buf_x_q[sidx_q];
  assign cur_y     = buf_y_q[sidx_q];
  assign mac_x     = (state_q == StInferMac) ? infer_x_q : cur_x;
  assign mac_a     = mac_x[mac_idx*DATA_W +: DATA_W];
  assign mac_b     = w_q[mac_idx];
  assign mac_step  = (state_q == StTrainMac) || (state_q == StInferMac);
  assign mac_clear = (state_q == StIdle) || (state_q == StDone);
  assign epoch_cnt = epoch_q;

  // Activation is strictly positive; zero predicts 0.
  assign act      = !mac_acc[ACC_W-1] && (mac_acc != '0);
  assign mis      = (cur_y != act);
  assign err_next = err_q + CntW'(mis);

  for (genvar k = 0; k < INP_DIM; k++) begin : g_wout
    assign w_out[k*W_W +: W_W] = w_q[k];
  end

`ifdef PERCEPTRON_BIAS_EN
  logic signed [W_W-1:0] bias_q;
  logic signed [W_W-1:0] bias_upd;
  assign mac_init = ACC_W'(bias_q);
  assign bias_upd = W_W'(sat_add(int'(bias_q), cur_y ? 1 : -1, W_W));
`else
  assign mac_init = '0;
`endif

  always_comb begin
    xk = '0;
    for (int k = 0; k < INP_DIM; k++) begin
      xk       = cur_x[k*DATA_W +: DATA_W];
      w_upd[k] = W_W'(sat_add(int'(w_q[k]), cur_y ? int'(xk) : -int'(xk), W_W));
    end
  end

  perceptron_mac #(
    .INP_DIM (INP_DIM),
    .DATA_W  (DATA_W),
    .W_W     (W_W),
    .ACC_W   (ACC_W),
    .IDX_W   (EIdxW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mac_clear),
    .step  (mac_step),
    .init  (mac_init),
    .a     (mac_a),
    .b     (mac_b),
    .idx   (mac_idx),
    .last  (mac_last),
    .sum   (mac_sum),
    .acc   (mac_acc)
  );

  // Sample storage carries no reset; only the count qualifies its contents.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      buf_x_q[cnt_q[SIdxW-1:0]] <= load_x;
      buf_y_q[cnt_q[SIdxW-1:0]] <= load_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      w_q         <= '{default: '0};
      cnt_q       <= '0;
      err_q       <= '0;
      sidx_q      <= '0;
      epoch_q     <= '0;
      infer_x_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      pred_valid  <= 1'b0;
      pred        <= 1'b0;
      load_ready  <= 1'b1;
      infer_ready <= 1'b0;
`ifdef PERCEPTRON_BIAS_EN
      bias_q      <= '0;
`endif
    end else begin
      pred_valid <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start && (cnt_q == NFull)) begin
            state_q     <= StTrainMac;
            busy        <= 1'b1;
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch_q     <= '0;
            err_q       <= '0;
            sidx_q      <= '0;
            load_ready  <= 1'b0;
            infer_ready <= 1'b0;
          end else if (load_acc) begin
            cnt_q       <= cnt_q + CntW'(1);
            load_ready  <= (cnt_q + CntW'(1)) < NFull;
            state_q     <= StIdle;
            done        <= 1'b0;
            infer_ready <= 1'b0;
          end else if ((state_q == StDone) && infer_valid) begin
            state_q     <= StInferMac;
            infer_x_q   <= infer_x;
            infer_ready <= 1'b0;
            load_ready  <= 1'b0;
          end
        end
        StTrainMac: begin
          if (mac_last) state_q <= StTrainUpd;
        end
        StTrainUpd: begin
          if (mis) begin
            w_q <= w_upd;
`ifdef PERCEPTRON_BIAS_EN
            bias_q <= bias_upd;
`endif
          end
          if (sidx_q == SLast) begin
            epoch_q <= epoch_q + EpW'(1);
            if ((err_next == '0) || ((epoch_q + EpW'(1)) == EpMax)) begin
              state_q     <= StDone;
              busy        <= 1'b0;
              done        <= 1'b1;
              converged   <= (err_next == '0);
              infer_ready <= 1'b1;
              load_ready  <= cnt_q < NFull;
            end else begin
              err_q   <= '0;
              sidx_q  <= '0;
              state_q <= StTrainMac;
            end
          end else begin
            err_q   <= err_next;
            sidx_q  <= sidx_q + SIdxW'(1);
            state_q <= StTrainMac;
          end
        end
        StInferMac: begin
          if (mac_last) begin
            pred        <= !mac_sum[ACC_W-1] && (mac_sum != '0);
            pred_valid  <= 1'b1;
            state_q     <= StDone;
            infer_ready <= 1'b1;
            load_ready  <= cnt_q < NFull;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Parametrised online perceptron trainer. It buffers N_SAMPLES labelled training vectors and runs sequential epochs of the perceptron learning rule until either one full epoch has zero errors or MAX_EPOCHS is reached. It then answers single-vector inference requests with the learned weights. It replaces the fixed 3-sample, 2-input perceptron and sits behind the pin-level wrapper, which drives the load, train and infer handshakes.

## Interface
- INP_DIM, 2, input vector dimension (≥1)
- N_SAMPLES, 4, training buffer depth (≥1)
- DATA_W, 8, signed width of each input element
- W_W, 8, signed width of each weight (and of the bias)
- ACC_W, 20, signed accumulator width, ≥ DATA_W+W_W+clog2(INP_DIM+1)
- MAX_EPOCHS, 15, epoch limit
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- load_valid  in  1  training sample offered
- load_ready  out  1  buffer accepts sample
- load_x  in  INP_DIM*DATA_W  signed elements, element 0 in LSBs
- load_y  in  1  target label (0/1)
- start  in  1  one-cycle pulse, begin training
- busy  out  1  training in progress
- done  out  1  training finished (sticky until next start/reset)
- converged  out  1  valid with done: last epoch error-free
- epoch_cnt  out  clog2(MAX_EPOCHS+1)  epochs completed
- w_out  out  INP_DIM*W_W  current weights, flattened
- infer_valid  in  1  inference request
- infer_ready  out  1  inference engine idle
- infer_x  in  INP_DIM*DATA_W  query vector
- pred_valid  out  1  one-cycle pulse
- pred  out  1  prediction

## Operation
- States: IDLE, TRAIN_MAC, TRAIN_UPD, DONE, INFER_MAC.
- Reset: state IDLE; weights, bias, sample count, epoch_cnt 0; busy, done, converged, pred_valid, pred 0; load_ready 1; infer_ready 0.
- Load: load_ready=1 in IDLE and DONE while count<N_SAMPLES. A sample is accepted on load_valid&&load_ready; count increments. Loading in DONE clears done.
- start is accepted in IDLE/DONE only when count==N_SAMPLES. Otherwise it is ignored. start while busy is ignored.
- On start: epoch_cnt=0, error counter=0, sample index=0. Weights are not cleared; training continues from the current weights.
- TRAIN_MAC: one multiply-accumulate per cycle over INP_DIM elements. acc = Σ x[k]*w[k] (+ bias).
- TRAIN_UPD:
  - act = (acc>0).
  - delta = y − act ∈ {−1,0,+1}.
  - If delta≠0: w[k] += delta*x[k] with each sum saturated to the signed W_W range, and the error counter increments.
  - Index advances.
  - At the last index: epoch_cnt++. If errors==0, go to DONE with converged=1. Else if epoch_cnt==MAX_EPOCHS, go to DONE with converged=0. Else clear errors, reset index to 0 and start the next epoch.
- DONE: done=1, infer_ready=1. infer_valid&&infer_ready captures infer_x and enters INFER_MAC.
- INFER_MAC: after INP_DIM MAC cycles, pred=(acc>0) with pred_valid high for one cycle. Return to DONE.
- Clearing the buffer: a start in DONE retrains on the same buffer. Reset is the only clear.

## Timing
- Per training sample: INP_DIM+1 cycles. Epoch: N_SAMPLES*(INP_DIM+1) cycles.
- start accepted at edge t: busy=1 from t+1.
- done/converged asserted the cycle after the final TRAIN_UPD, with busy low in the same cycle.
- Inference latency: pred_valid at t+INP_DIM+1 after acceptance at t. infer_ready low meanwhile.
- w_out updates the cycle after TRAIN_UPD.
- rst_n low mid-training or mid-inference aborts at the next edge with all reset values. pred_valid is never issued for an aborted query.

## Configuration
- PERCEPTRON_BIAS_EN defined: adds a signed W_W bias, reset 0, included in acc. Its update is bias += delta, saturated.
- Undefined: no bias register, so acc is weights only and a zero vector always predicts 0.

## Structure
- perceptron_pkg: state enum, saturating-add function, clog2-derived count widths.
- One sub-module, perceptron_mac: sequential single-multiplier accumulator with clear/step/done. It is shared by training and inference.

## Test plan
- Defaults, bias off. Load (1,0)→1, (0,1)→0, (2,0)→1, (0,2)→0, then start → done=1, converged=1, epoch_cnt=2, w_out=(1,0) after 2*4*3=24 busy cycles.
- XOR set (0,0)→0, (1,1)→0, (1,0)→1, (0,1)→1 → done=1, converged=0, epoch_cnt=15.
- Five load_valid pulses with N_SAMPLES=4 → 4 accepted, load_ready=0 on the 5th. start with only 3 loaded → ignored, busy stays 0.
- After test 1, infer_x=(3,−1) → pred_valid at +3 cycles, pred=1. infer_x=(−2,5) → pred=0.
- rst_n low for one cycle mid-epoch → all outputs at reset values. A subsequent start is ignored (count=0).
- Bias on, load (0,0)→1 ×4 → bias=1, converged=1, epoch_cnt=2.
